uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UartTx serializer between NUM_REQ byte-stream requesters. Round-robin grants per
//  packet: the owner keeps the transmitter until it sends a byte flagged last, or goes silent too long.
//  Sits between producers (status/log/echo sources) and UartTx; drives tx_data/tx_start, watches tx_busy.
// PARAMETERS
//  NUM_REQ       4      number of requesters, 2..8
//  LOCK_TIMEOUT  50000  owner-idle cycles before a lock is force-released; 0 = never release
//  ID_W          2      width of grant_id; must equal clog2(NUM_REQ)
// PORTS
//  clk          in   1            single system clock; all logic on posedge clk
//  rst_n        in   1            reset, asynchronous assert, active-low
//  req_valid    in   NUM_REQ      requester i presents a byte
//  req_data     in   8*NUM_REQ    byte of requester i in bits [8i+7:8i]
//  req_last     in   NUM_REQ      byte of requester i ends its packet
//  req_ready    out  NUM_REQ      one-hot 1-cycle pulse: byte of requester i accepted this cycle
//  tx_data      out  8            byte to UartTx; stable from START until the next accept
//  tx_start     out  1            1-cycle pulse to UartTx
//  tx_busy      in   1            UartTx busy (rises the cycle after tx_start, falls after stop bit)
//  grant_valid  out  1            a requester currently owns the transmitter
//  grant_id     out  ID_W         index of the owner; meaningful only when grant_valid=1
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, req_ready=0, tx_start=0, tx_data=8'h00, grant_valid=0,
//   grant_id=0, rr_ptr=NUM_REQ-1 (requester 0 has first priority), lock timer=0.
//   Reset mid-byte: tx_start is dropped at once. A byte already loaded in UartTx finishes on its own.
//  FSM:
//   IDLE: if any req_valid, pick the first valid index searching rr_ptr+1, +2, ... (mod NUM_REQ).
//    Same cycle: pulse req_ready[win], capture req_data/req_last, set grant_valid=1, grant_id=win,
//    rr_ptr=win. Go to START.
//   START: tx_start=1 for exactly this cycle; tx_data already holds the byte. Go to WAIT_BUSY.
//   WAIT_BUSY: stay until tx_busy=1, then go to WAIT_DONE. This covers the 1-cycle busy latency.
//   WAIT_DONE: stay until tx_busy=0.
//    If the captured last=1: grant_valid=0, go to IDLE.
//    Otherwise go to HOLD with the lock timer cleared.
//   HOLD: the owner keeps the grant.
//    If req_valid[grant_id]=1: accept it (req_ready pulse, capture), go to START. Timer cleared.
//    Otherwise the timer increments. When LOCK_TIMEOUT!=0 and timer==LOCK_TIMEOUT-1:
//     grant_valid=0, go to IDLE.
//    Other requesters' req_valid is ignored in HOLD.
//  Latency: accept -> tx_start is 1 cycle. Back-to-back bytes of one packet: next accept is
//   1 cycle after tx_busy falls.
//  req_ready is only asserted for the granted index. Requesters must hold valid/data/last
//   stable until ready.
//  Simultaneous requests in IDLE: round-robin only, no fixed priority. After winner k,
//   requester k+1 is searched first.
//  Wrap-around: the rr search index and the rr_ptr increment wrap modulo NUM_REQ.
//   The lock timer saturates (it never wraps) when LOCK_TIMEOUT=0.
//  tx_busy=1 while in IDLE (an orphan byte after reset): no accept until tx_busy=0.
// STRUCTURE
//  Shared package uart_pkg: FSM state encoding (IDLE, START, WAIT_BUSY, WAIT_DONE, HOLD),
//   UART_BYTE_W=8, and a clog2 function.
//  One sub-module, rr_pick: combinational round-robin picker.
//   Inputs: NUM_REQ request vector, ptr. Outputs: found, index.
//  Timer width: clog2(LOCK_TIMEOUT+1).
// TESTING (bench models UartTx: busy rises 1 cycle after start, stays high 10 baud periods)
//  1. Single packet: req0 sends 8'h45 then 8'h0A (last) -> two tx_start pulses, data 45 then 0A;
//     grant_valid=0 after the second busy fall.
//  2. Contention: req0, req1, req2 all valid with 1-byte packets -> service order 0, 1, 2.
//     Re-raise all -> order 0, 1, 2 again.
//  3. Packet lock: req1 sends a 3-byte packet while req0 is valid throughout -> req1 bytes are
//     not interleaved; req0 is granted only after req1's last byte.
//  4. Timeout: LOCK_TIMEOUT=20, req2 sends 1 non-last byte then drops valid -> 20 cycles in HOLD,
//     then grant released; waiting req3 is granted next cycle.
//  5. Reset mid-transfer: rst_n=0 during WAIT_DONE -> all outputs at reset values at once.
//     After release, tx_busy still high -> no accept until it falls.
//  6. Busy latency: tx_busy delayed 3 cycles after start -> FSM waits in WAIT_BUSY.
//     No second tx_start and no premature accept.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, byte width and a
// constant-friendly ceiling-log2 helper.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        HOLD      = 3'd4
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between byte-stream requesters, the arbiter and the UartTx serializer.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);

    // Requester i hands over a byte when req_valid[i] and req_ready[i] are both high on a
    // rising clock edge; valid/data/last must stay stable until that cycle, and ready is
    // never raised for a requester that does not currently present valid.
    logic [NUM_REQ-1:0]             req_valid;
    logic [UART_BYTE_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]             req_last;
    logic [NUM_REQ-1:0]             req_ready;
    logic [UART_BYTE_W-1:0]         tx_data;
    logic                           tx_start;
    logic                           tx_busy;
    logic                           grant_valid;
    logic [ID_W-1:0]                grant_id;

    modport master (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_start, grant_valid, grant_id
    );

    modport slave (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_start, grant_valid, grant_id
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at ptr+1, ptr+2, ... modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    index
);

    logic [ID_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        // ptr itself is searched last, so the previous winner yields to everyone else
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UartTx between NUM_REQ byte-stream requesters with per-packet round-robin
// grants; an owner keeps the transmitter until its last byte or until it stays silent too long.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int ID_W         = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.master bus,
    output state_t            fsm_state
);

    localparam int TMR_W = (clog2(LOCK_TIMEOUT + 1) < 1) ? 1 : clog2(LOCK_TIMEOUT + 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [ID_W-1:0]        rr_ptr;
    logic                   pick_found;
    logic [ID_W-1:0]        pick_idx;
    logic                   accept;
    logic [ID_W-1:0]        accept_id;
    logic                   release_grant;
    logic                   timer_clr;
    logic                   timer_inc;
    logic                   hold_valid;
    logic [UART_BYTE_W-1:0] sel_data;
    logic                   sel_last;
    logic [NUM_REQ-1:0]     ready_vec;
    logic [UART_BYTE_W-1:0] tx_data_q;
    logic                   last_q;
    logic                   grant_valid_q;
    logic [ID_W-1:0]        grant_id_q;
    logic [TMR_W-1:0]       timer;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .index (pick_idx)
    );

    always_comb begin
        hold_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant_id_q) hold_valid = bus.req_valid[i];
        end
    end

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        accept_id     = grant_id_q;
        release_grant = 1'b0;
        timer_clr     = 1'b0;
        timer_inc     = 1'b0;
        case (state)
            IDLE: begin
                // an orphan byte still shifting out after reset blocks new grants
                if (!bus.tx_busy && pick_found) begin
                    accept    = 1'b1;
                    accept_id = pick_idx;
                    state_nxt = START;
                end
            end
            START:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (bus.tx_busy) state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (last_q) begin
                        release_grant = 1'b1;
                        state_nxt     = IDLE;
                    end else begin
                        timer_clr = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (hold_valid) begin
                    accept    = 1'b1;
                    state_nxt = START;
                end else begin
                    timer_inc = 1'b1;
                    if (LOCK_TIMEOUT != 0 && timer == TMR_W'(LOCK_TIMEOUT - 1)) begin
                        release_grant = 1'b1;
                        state_nxt     = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sel_data  = '0;
        sel_last  = 1'b0;
        ready_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == accept_id) begin
                sel_data     = bus.req_data[i*UART_BYTE_W +: UART_BYTE_W];
                sel_last     = bus.req_last[i];
                ready_vec[i] = accept;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= ID_W'(NUM_REQ - 1);
            tx_data_q     <= '0;
            last_q        <= 1'b0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                tx_data_q     <= sel_data;
                last_q        <= sel_last;
                grant_valid_q <= 1'b1;
                grant_id_q    <= accept_id;
                rr_ptr        <= accept_id;
            end else if (release_grant) begin
                grant_valid_q <= 1'b0;
            end
        end
    end

    // Saturating so a never-release configuration cannot wrap back into a stale compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (accept || timer_clr) begin
            timer <= '0;
        end else if (timer_inc && timer != {TMR_W{1'b1}}) begin
            timer <= timer + TMR_W'(1);
        end
    end

    assign bus.req_ready   = ready_vec;
    assign bus.tx_start    = (state == START);
    assign bus.tx_data     = tx_data_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_id    = grant_id_q;
    assign fsm_state       = state;

endmodule
